// File: rtl/relation_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// relation_arbiter_pkg
//   Shared definitions for the relation arbiter slice: FSM state encoding,
//   relation flag indices, default widths and a small bit-count helper used
//   by the classifier.
// -----------------------------------------------------------------------------
package relation_arbiter_pkg;

    // Default operand width and event counter width
    localparam int W_DEF     = 3;
    localparam int CNT_W_DEF = 8;

    // Transaction FSM: one evaluation per grant, no stalls
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    // Bit positions inside the 5-bit relation flag vector
    localparam int GRAY   = 0;
    localparam int EX3    = 1;
    localparam int MORE   = 2;
    localparam int LESS   = 3;
    localparam int NONE   = 4;
    localparam int NFLAGS = 5;

    // Number of set bits in a word (callers zero-extend narrower values)
    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/relation_arbiter_if.sv
// -----------------------------------------------------------------------------
// relation_arbiter_if
//   Bundles the requester handshake, operand buses, counter clear and all
//   result/status outputs of the relation arbiter.
//   master : operand producers / status logic (drives req, operands, clr_cnt)
//   slave  : the arbiter itself (drives gnt, busy, done, res_*, cnt_*)
// -----------------------------------------------------------------------------
interface relation_arbiter_if
    import relation_arbiter_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic [1:0]       req;
    logic [W-1:0]     a0;
    logic [W-1:0]     b0;
    logic [W-1:0]     a1;
    logic [W-1:0]     b1;
    logic             clr_cnt;
    logic [1:0]       gnt;
    logic             busy;
    logic [1:0]       done;
    logic             res_gray;
    logic             res_ex3;
    logic             res_more;
    logic             res_less;
    logic             res_none;
    logic [CNT_W-1:0] cnt_gray;
    logic [CNT_W-1:0] cnt_ex3;
    logic [CNT_W-1:0] cnt_more;
    logic [CNT_W-1:0] cnt_less;
    logic [CNT_W-1:0] cnt_none;

    modport master (
        output req, a0, b0, a1, b1, clr_cnt,
        input  gnt, busy, done,
        input  res_gray, res_ex3, res_more, res_less, res_none,
        input  cnt_gray, cnt_ex3, cnt_more, cnt_less, cnt_none
    );

    modport slave (
        input  req, a0, b0, a1, b1, clr_cnt,
        output gnt, busy, done,
        output res_gray, res_ex3, res_more, res_less, res_none,
        output cnt_gray, cnt_ex3, cnt_more, cnt_less, cnt_none
    );
endinterface

// File: rtl/relation_arbiter_core.sv
// -----------------------------------------------------------------------------
// code_relation_core
//   Purely combinational classifier of two W-bit codes.
//   a, b  : operands
//   flags : [GRAY] Hamming distance 1, [EX3] |a-b|==3, [MORE] a-b==+1,
//           [LESS] a-b==-1, [NONE] none of the above
//   The difference is taken in W+1 signed bits so there is no modulo wrap:
//   a=0,b=7 gives -7, which is not "less".
// -----------------------------------------------------------------------------
module code_relation_core
    import relation_arbiter_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    output logic [NFLAGS-1:0] flags
);
    localparam logic signed [W:0] POS1 = (W+1)'(1);
    localparam logic signed [W:0] POS3 = (W+1)'(3);
    localparam logic signed [W:0] NEG1 = -POS1;
    localparam logic signed [W:0] NEG3 = -POS3;

    logic signed [W:0] diff_s;
    logic [W-1:0]      xor_s;

    // Signed difference, bit distance and the five independent relation flags
    always_comb begin
        diff_s = $signed({1'b0, a}) - $signed({1'b0, b});
        xor_s  = a ^ b;
        flags  = {NFLAGS{1'b0}};
        flags[GRAY] = (popcount(32'(xor_s)) == 6'd1);
        flags[EX3]  = (diff_s == POS3) || (diff_s == NEG3);
        flags[MORE] = (diff_s == POS1);
        flags[LESS] = (diff_s == NEG1);
        flags[NONE] = ~(flags[GRAY] | flags[EX3] | flags[MORE] | flags[LESS]);
    end
endmodule

// File: rtl/relation_arbiter.sv
// -----------------------------------------------------------------------------
// relation_arbiter
//   Shares one code_relation_core between two requesters. A round-robin
//   arbiter grants the classifier, latches the winner's (A,B), registers the
//   relation flags and pulses done[winner]; saturating counters track how
//   often each relation was seen.
//   clk   : system clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : relation_arbiter_if.slave (req/operands/clr_cnt in,
//           gnt/busy/done/res_*/cnt_* out)
//   Transaction: IDLE (sample req, latch) -> EVAL (register result, count)
//   -> RESP (done pulse) -> IDLE.
// -----------------------------------------------------------------------------
module relation_arbiter
    import relation_arbiter_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    relation_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state_r;
    state_t            state_s;
    logic              last_r;      // index of the last granted requester
    logic              win_s;       // index of the requester that would win now
    logic              take_s;      // a new transaction starts at this edge
    logic [1:0]        gnt_r;
    logic [1:0]        gnt_s;
    logic [1:0]        done_r;
    logic [1:0]        done_s;
    logic              busy_r;
    logic              busy_s;
    logic [W-1:0]      opa_r;
    logic [W-1:0]      opb_r;
    logic [NFLAGS-1:0] flags_s;
    logic [NFLAGS-1:0] res_r;

    // Round-robin winner: a lone request wins, a tie goes to the one not served last
    always_comb begin
        win_s = 1'b0;
        case (bus.req)
            2'b01:   win_s = 1'b0;
            2'b10:   win_s = 1'b1;
            2'b11:   win_s = ~last_r;
            default: win_s = 1'b0;
        endcase
        take_s = (state_r == IDLE) && (bus.req != 2'b00);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    state_s = EVAL;
                end else begin
                    state_s = IDLE;
                end
            end
            EVAL:    state_s = RESP;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered status outputs
    always_comb begin
        gnt_s  = 2'b00;
        done_s = 2'b00;
        case (state_r)
            IDLE: begin
                if (take_s) begin
                    if (win_s) begin
                        gnt_s = 2'b10;
                    end else begin
                        gnt_s = 2'b01;
                    end
                end else begin
                    gnt_s = 2'b00;
                end
            end
            EVAL: begin
                // grant stays up into RESP; done fires for the granted side
                gnt_s  = gnt_r;
                done_s = gnt_r;
            end
            RESP: begin
                gnt_s  = 2'b00;
                done_s = 2'b00;
            end
            default: begin
                gnt_s  = 2'b00;
                done_s = 2'b00;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // Status output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_r  <= 2'b00;
            done_r <= 2'b00;
            busy_r <= 1'b0;
        end else begin
            gnt_r  <= gnt_s;
            done_r <= done_s;
            busy_r <= busy_s;
        end
    end

    // Operand latch and round-robin pointer, both updated on every grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_r <= 1'b1;   // pretend requester 1 was served last so req[0] wins first
            opa_r  <= {W{1'b0}};
            opb_r  <= {W{1'b0}};
        end else if (take_s) begin
            last_r <= win_s;
            opa_r  <= win_s ? bus.a1 : bus.a0;
            opb_r  <= win_s ? bus.b1 : bus.b0;
        end else begin
            last_r <= last_r;
            opa_r  <= opa_r;
            opb_r  <= opb_r;
        end
    end

    code_relation_core #(.W(W)) u_core (
        .a     (opa_r),
        .b     (opb_r),
        .flags (flags_s)
    );

    // Result register: loads at the EVAL edge, holds otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_r <= {NFLAGS{1'b0}};
        end else if (state_r == EVAL) begin
            res_r <= flags_s;
        end else begin
            res_r <= res_r;
        end
    end

    // One saturating event counter per relation flag
    for (genvar g = 0; g < NFLAGS; g++) begin : g_cnt
        logic [CNT_W-1:0] cnt_r;

        // Clear has priority over a coincident increment
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (bus.clr_cnt) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if ((state_r == EVAL) && flags_s[g] && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign bus.gnt      = gnt_r;
    assign bus.done     = done_r;
    assign bus.busy     = busy_r;
    assign bus.res_gray = res_r[GRAY];
    assign bus.res_ex3  = res_r[EX3];
    assign bus.res_more = res_r[MORE];
    assign bus.res_less = res_r[LESS];
    assign bus.res_none = res_r[NONE];
    assign bus.cnt_gray = g_cnt[GRAY].cnt_r;
    assign bus.cnt_ex3  = g_cnt[EX3].cnt_r;
    assign bus.cnt_more = g_cnt[MORE].cnt_r;
    assign bus.cnt_less = g_cnt[LESS].cnt_r;
    assign bus.cnt_none = g_cnt[NONE].cnt_r;
endmodule

// File: tb/tb_relation_arbiter.sv
// -----------------------------------------------------------------------------
// tb_relation_arbiter
//   Directed self-checking bench for relation_arbiter (W=3, CNT_W=2).
//   Flags are compared as {gray, ex3, more, less, none}.
// -----------------------------------------------------------------------------
module tb_relation_arbiter;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    relation_arbiter_if #(.W(3), .CNT_W(2)) bus ();

    relation_arbiter #(.W(3), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [4:0] flags_s;
    assign flags_s = {bus.res_gray, bus.res_ex3, bus.res_more, bus.res_less, bus.res_none};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction with req released during the done cycle
    task automatic txn(input logic [1:0] r, input logic [1:0] eg, input string tag);
        bus.req = r;
        step();
        chk({tag, "_gnt"},   32'(bus.gnt), 32'(eg));
        chk({tag, "_busy"},  32'(bus.busy), 32'd1);
        chk({tag, "_done0"}, 32'(bus.done), 32'd0);
        step();
        chk({tag, "_done"},  32'(bus.done), 32'(eg));
        chk({tag, "_gnth"},  32'(bus.gnt), 32'(eg));
        bus.req = 2'b00;
        step();
        chk({tag, "_donel"}, 32'(bus.done), 32'd0);
        chk({tag, "_idle"},  32'(bus.busy), 32'd0);
        chk({tag, "_gntl"},  32'(bus.gnt), 32'd0);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst_n       = 1'b0;
        bus.req     = 2'b00;
        bus.a0      = 3'd0;
        bus.b0      = 3'd0;
        bus.a1      = 3'd0;
        bus.b1      = 3'd0;
        bus.clr_cnt = 1'b0;
        #1;
        chk("rst_gnt",  32'(bus.gnt), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_flags", 32'(flags_s), 32'd0);
        chk("rst_cntg", 32'(bus.cnt_gray), 32'd0);
        chk("rst_cntn", 32'(bus.cnt_none), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // 3 vs 2: gray and more
        bus.a0 = 3'd3; bus.b0 = 3'd2;
        txn(2'b01, 2'b01, "t2");
        chk("t2_flags", 32'(flags_s), 32'(5'b10100));
        chk("t2_cntg",  32'(bus.cnt_gray), 32'd1);
        chk("t2_cntm",  32'(bus.cnt_more), 32'd1);
        chk("t2_cnte",  32'(bus.cnt_ex3), 32'd0);
        chk("t2_cntn",  32'(bus.cnt_none), 32'd0);

        // classifier cases on requester 1 (also: lone req[1] after its own grant)
        bus.a1 = 3'd1; bus.b1 = 3'd4;
        txn(2'b10, 2'b10, "ex3n");
        chk("ex3n_flags", 32'(flags_s), 32'(5'b01000));
        chk("ex3n_cnte",  32'(bus.cnt_ex3), 32'd1);
        bus.a1 = 3'd0; bus.b1 = 3'd7;
        txn(2'b10, 2'b10, "nowrap");
        chk("nowrap_flags", 32'(flags_s), 32'(5'b00001));
        chk("nowrap_cntl",  32'(bus.cnt_less), 32'd0);
        bus.a1 = 3'd5; bus.b1 = 3'd5;
        txn(2'b10, 2'b10, "equal");
        chk("equal_flags", 32'(flags_s), 32'(5'b00001));
        chk("equal_cntn",  32'(bus.cnt_none), 32'd2);
        bus.a1 = 3'd4; bus.b1 = 3'd5;
        txn(2'b10, 2'b10, "less");
        chk("less_flags", 32'(flags_s), 32'(5'b10010));
        chk("less_cntl",  32'(bus.cnt_less), 32'd1);
        chk("less_cntg",  32'(bus.cnt_gray), 32'd2);
        bus.a1 = 3'd6; bus.b1 = 3'd3;
        txn(2'b10, 2'b10, "ex3p");
        chk("ex3p_flags", 32'(flags_s), 32'(5'b01000));
        chk("ex3p_cnte",  32'(bus.cnt_ex3), 32'd2);

        // fairness from reset with both requests held
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        bus.a0 = 3'd3; bus.b0 = 3'd2;
        bus.a1 = 3'd1; bus.b1 = 3'd4;
        bus.req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_gnt", 32'(bus.gnt), (i % 2 == 0) ? 32'd1 : 32'd2);
            step();
            chk("rr_done", 32'(bus.done), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("rr_flags", 32'(flags_s), (i % 2 == 0) ? 32'(5'b10100) : 32'(5'b01000));
            step();
            chk("rr_idle", 32'(bus.busy), 32'd0);
        end
        bus.req = 2'b00;
        chk("rr_cntg", 32'(bus.cnt_gray), 32'd2);
        chk("rr_cnte", 32'(bus.cnt_ex3), 32'd2);

        // standalone clear, then saturation at 3
        bus.clr_cnt = 1'b1;
        step();
        bus.clr_cnt = 1'b0;
        chk("clr_cntg", 32'(bus.cnt_gray), 32'd0);
        chk("clr_cnte", 32'(bus.cnt_ex3), 32'd0);
        for (int i = 0; i < 5; i++) begin
            txn(2'b01, 2'b01, "sat");
        end
        chk("sat_cntg", 32'(bus.cnt_gray), 32'd3);
        chk("sat_cntm", 32'(bus.cnt_more), 32'd3);

        // clear coincident with the EVAL update
        bus.req = 2'b01;
        step();
        bus.clr_cnt = 1'b1;
        step();
        chk("clrev_done",  32'(bus.done), 32'd1);
        chk("clrev_cntg",  32'(bus.cnt_gray), 32'd0);
        chk("clrev_cntm",  32'(bus.cnt_more), 32'd0);
        chk("clrev_flags", 32'(flags_s), 32'(5'b10100));
        bus.clr_cnt = 1'b0;
        bus.req = 2'b00;
        step();
        txn(2'b01, 2'b01, "post");
        chk("post_cntg", 32'(bus.cnt_gray), 32'd1);

        // reset asserted during EVAL: everything clears at once, no done
        bus.req = 2'b01;
        step();
        chk("ab_busy", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ab_gnt",   32'(bus.gnt), 32'd0);
        chk("ab_busy0", 32'(bus.busy), 32'd0);
        chk("ab_done",  32'(bus.done), 32'd0);
        chk("ab_flags", 32'(flags_s), 32'd0);
        chk("ab_cntg",  32'(bus.cnt_gray), 32'd0);
        bus.req = 2'b00;
        step();
        chk("ab_done1", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        step();
        chk("ab_done2", 32'(bus.done), 32'd0);
        chk("ab_idle",  32'(bus.busy), 32'd0);

        // req dropped during EVAL: transaction still completes once
        bus.req = 2'b01;
        step();
        chk("drop_gnt", 32'(bus.gnt), 32'd1);
        bus.req = 2'b00;
        step();
        chk("drop_done",  32'(bus.done), 32'd1);
        chk("drop_flags", 32'(flags_s), 32'(5'b10100));
        step();
        chk("drop_done0", 32'(bus.done), 32'd0);
        step();
        chk("drop_done1", 32'(bus.done), 32'd0);
        chk("drop_idle",  32'(bus.busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
